// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage-record layout and ISA opcodes.
package pipeline_hazard_ctrl_pkg;

  // Stage record bit layout: {dst, is_hlt, is_load, reg_write, valid}
  localparam int REC_VALID     = 0;
  localparam int REC_REG_WRITE = 1;
  localparam int REC_IS_LOAD   = 2;
  localparam int REC_IS_HLT    = 3;
  localparam int REC_DST_LSB   = 4;

  function automatic int rec_w(input int reg_aw);
    return REC_DST_LSB + reg_aw;
  endfunction

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LHB = 4'hA;
  localparam logic [3:0] OP_LLB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_mux.sv
// One ID operand: EX > MEM > WB > RF priority select, plus the EX-load hit used for load-use.
module hazard_fwd_mux #(
  parameter int DATA_W        = 16,
  parameter int REG_AW        = 4,
  parameter int ZERO_REG_HARD = 1
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              use_src_i,
  input  logic              ex_wr_i,
  input  logic              ex_ld_i,
  input  logic [REG_AW-1:0] ex_dst_i,
  input  logic              mem_wr_i,
  input  logic [REG_AW-1:0] mem_dst_i,
  input  logic              wb_wr_i,
  input  logic [REG_AW-1:0] wb_dst_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic [DATA_W-1:0] ex_data_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ex_load_hit_o
);

  logic live;
  logic ex_hit;

  assign live   = use_src_i && !((ZERO_REG_HARD != 0) && (src_i == '0));
  assign ex_hit = live && ex_wr_i && (ex_dst_i == src_i);

  // A load in EX has no data yet, so fall through to older stages.
  assign ex_load_hit_o = ex_hit && ex_ld_i;

  always_comb begin
    data_o = rf_data_i;
    if (ex_hit && !ex_ld_i)                      data_o = ex_data_i;
    else if (live && mem_wr_i && mem_dst_i == src_i) data_o = mem_data_i;
    else if (live && wb_wr_i && wb_dst_i == src_i)   data_o = wb_data_i;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding, load-use bubble, branch flush, memory freeze, HLT drain.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int REG_AW         = 4,
  parameter int ZERO_REG_HARD  = 1,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use_src1,
  input  logic              id_use_src2,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_is_hlt,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] id_rf_data1,
  input  logic [DATA_W-1:0] id_rf_data2,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] id_data1,
  output logic [DATA_W-1:0] id_data2,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              mem_wb_flush,
  output logic [2:0]        stage_valid,
  output logic              hlt
);

  localparam int RW = rec_w(REG_AW);

  logic [RW-1:0] ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_rec;
  logic          fetch_stop_q, fetch_stop_d, hlt_q, hlt_d;
  logic          busy, br, lu, ld_hit;
  logic          unused_wb_ld;

  logic [1:0][REG_AW-1:0] src;
  logic [1:0]             use_src, ex_ld_hit;
  logic [1:0][DATA_W-1:0] rf_data, fwd_data;

  assign id_rec  = {id_dst, id_is_hlt, id_is_load, id_reg_write, id_valid};
  assign src     = {id_src2, id_src1};
  assign use_src = {id_use_src2, id_use_src1};
  assign rf_data = {id_rf_data2, id_rf_data1};

  for (genvar g = 0; g < 2; g++) begin : g_op
    hazard_fwd_mux #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG_HARD(ZERO_REG_HARD)
    ) u_fwd (
      .src_i        (src[g]),
      .use_src_i    (use_src[g]),
      .ex_wr_i      (ex_q[REC_VALID] & ex_q[REC_REG_WRITE]),
      .ex_ld_i      (ex_q[REC_IS_LOAD]),
      .ex_dst_i     (ex_q[REC_DST_LSB +: REG_AW]),
      .mem_wr_i     (mem_q[REC_VALID] & mem_q[REC_REG_WRITE]),
      .mem_dst_i    (mem_q[REC_DST_LSB +: REG_AW]),
      .wb_wr_i      (wb_q[REC_VALID] & wb_q[REC_REG_WRITE]),
      .wb_dst_i     (wb_q[REC_DST_LSB +: REG_AW]),
      .rf_data_i    (rf_data[g]),
      .ex_data_i    (ex_result),
      .mem_data_i   (mem_result),
      .wb_data_i    (wb_result),
      .data_o       (fwd_data[g]),
      .ex_load_hit_o(ex_ld_hit[g])
    );
  end

  assign id_data1 = fwd_data[0];
  assign id_data2 = fwd_data[1];

  // Priority: memory freeze > taken branch > load-use.
  assign ld_hit = id_valid & (|ex_ld_hit);
  assign busy   = mem_busy;
  assign br     = ex_branch_taken & ex_q[REC_VALID] & ~busy;
  assign lu     = (LOAD_USE_STALL != 0) & ld_hit & ~busy & ~br;

  assign pc_stall     = busy | lu | fetch_stop_q;
  assign if_id_stall  = busy | lu;
  assign if_id_flush  = br | fetch_stop_q;
  assign id_ex_stall  = busy;
  assign id_ex_flush  = br | lu;
  assign ex_mem_stall = busy;
  assign mem_wb_flush = busy;
  assign stage_valid  = {wb_q[REC_VALID], mem_q[REC_VALID], ex_q[REC_VALID]};
  assign hlt          = hlt_q;
  assign unused_wb_ld = wb_q[REC_IS_LOAD];

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (busy) begin
      wb_d[REC_VALID] = 1'b0;
    end else begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = id_rec;
      if (br | lu) ex_d[REC_VALID] = 1'b0;
    end
    fetch_stop_d = fetch_stop_q | (id_is_hlt & id_valid & ~busy & ~br & ~lu);
    hlt_d        = hlt_q | (wb_q[REC_VALID] & wb_q[REC_IS_HLT]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      fetch_stop_q <= 1'b0;
      hlt_q        <= 1'b0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      fetch_stop_q <= fetch_stop_d;
      hlt_q        <= hlt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_src1, id_use_src2, id_reg_write, id_is_load, id_is_hlt;
  logic [3:0]  id_src1, id_src2, id_dst;
  logic        ex_branch_taken, mem_busy;
  logic [15:0] id_rf_data1, id_rf_data2, ex_result, mem_result, wb_result;
  logic [15:0] id_data1, id_data2;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, mem_wb_flush, hlt;
  logic [2:0]  stage_valid;
  logic [6:0]  ctl;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_hlt(id_is_hlt),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .id_rf_data1(id_rf_data1), .id_rf_data2(id_rf_data2),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .id_data1(id_data1), .id_data2(id_data2),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
    .stage_valid(stage_valid), .hlt(hlt)
  );

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic u1, input logic u2, input logic [3:0] d,
                        input logic rw, input logic ld, input logic hl);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_use_src1 = u1; id_use_src2 = u2;
    id_dst = d; id_reg_write = rw; id_is_load = ld; id_is_hlt = hl;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
    id_rf_data1 = 16'h0; id_rf_data2 = 16'h0;
    ex_result = 16'h0; mem_result = 16'h0; wb_result = 16'h0;
    #2;
    chk("rst_ctl", ctl, 7'b0);
    chk("rst_sv", stage_valid, 3'b000);
    chk("rst_hlt", hlt, 1'b0);
    chk("rst_data1", id_data1, 16'h0);
    id_rf_data1 = 16'h1111; id_rf_data2 = 16'h2222;
    ex_result = 16'h0042; mem_result = 16'hBEEF; wb_result = 16'h7777;
    #10 rst_n = 1'b1;
    tick();

    // ALU chain forwarding
    set_id(1, 4'd2, 4'd3, 1, 1, 4'd1, 1, 0, 0); #1;
    chk("add_ctl", ctl, 7'b0);
    chk("add_rf", id_data1, 16'h1111);
    tick();
    set_id(1, 4'd1, 4'd5, 1, 1, 4'd4, 1, 0, 0); #1;
    chk("ex_fwd", id_data1, 16'h0042);
    chk("ex_fwd_rf2", id_data2, 16'h2222);
    chk("ex_fwd_ctl", ctl, 7'b0);
    chk("ex_fwd_sv", stage_valid, 3'b001);
    tick();
    set_id(1, 4'd1, 4'd4, 1, 1, 4'd0, 0, 0, 0); #1;
    chk("mem_fwd", id_data1, 16'hBEEF);
    chk("mem_ex_fwd", id_data2, 16'h0042);
    tick();
    set_id(1, 4'd1, 4'd4, 1, 0, 4'd0, 0, 0, 0); #1;
    chk("wb_fwd", id_data1, 16'h7777);
    chk("nouse_rf", id_data2, 16'h2222);
    chk("full_sv", stage_valid, 3'b111);
    tick();
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd9, 1, 0, 0); tick();
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd9, 1, 0, 0); tick();
    set_id(1, 4'd9, 4'd9, 1, 1, 4'd0, 0, 0, 0); #1;
    chk("prio_ex_over_mem", id_data1, 16'h0042);
    idle(); repeat (3) tick();

    // Load-use
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd1, 1, 1, 0); tick();
    set_id(1, 4'd1, 4'd3, 1, 1, 4'd2, 1, 0, 0); #1;
    chk("lu_ctl", ctl, 7'b1100100);
    chk("lu_noexfwd", id_data1, 16'h1111);
    tick();
    chk("lu2_ctl", ctl, 7'b0);
    chk("lu2_sv", stage_valid, 3'b010);
    chk("lu2_memfwd", id_data1, 16'hBEEF);
    tick(); idle(); repeat (3) tick();

    // Taken branch overrides load-use
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd1, 1, 1, 0); tick();
    set_id(1, 4'd1, 4'd3, 1, 1, 4'd2, 1, 0, 0);
    ex_branch_taken = 1'b1; #1;
    chk("br_ctl", ctl, 7'b0010100);
    tick();
    ex_branch_taken = 1'b0; idle(); #1;
    chk("br_sv", stage_valid, 3'b010);
    repeat (3) tick();

    // Memory freeze
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd8, 1, 0, 0); tick();
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd7, 1, 0, 0); tick();
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd6, 1, 0, 0); tick();
    set_id(0, 4'd6, 4'd7, 1, 1, 4'd0, 0, 0, 0); #1;
    chk("busy_pre_sv", stage_valid, 3'b111);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_branch_taken = (i == 1);
      #1;
      chk("busy_ctl", ctl, 7'b1101011);
      tick();
      chk("busy_sv", stage_valid, 3'b011);
      chk("busy_ex_hold", id_data1, 16'h0042);
      chk("busy_mem_hold", id_data2, 16'hBEEF);
    end
    mem_busy = 1'b0; ex_branch_taken = 1'b0; #1;
    chk("unbusy_ctl", ctl, 7'b0);
    tick();
    chk("unbusy_sv", stage_valid, 3'b110);
    idle(); repeat (3) tick();

    // HLT behind a not-taken branch
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd1, 1, 0, 0); tick();
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0); tick();
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 1); #1;
    chk("hlt_id_ctl", ctl, 7'b0);
    tick();
    idle(); #1;
    chk("hlt_frz_ctl", ctl, 7'b1010000);
    chk("hlt_e1_sv", stage_valid, 3'b111);
    chk("hlt_e1", hlt, 1'b0);
    tick(); chk("hlt_e2", hlt, 1'b0);
    tick(); chk("hlt_e3", hlt, 1'b0);
    chk("hlt_e3_sv", stage_valid, 3'b100);
    tick(); chk("hlt_e4", hlt, 1'b1);
    repeat (3) tick();
    chk("hlt_sticky", hlt, 1'b1);
    chk("hlt_sticky_ctl", ctl, 7'b1010000);

    // Async reset with load-use pending
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd1, 1, 1, 0); tick();
    set_id(1, 4'd1, 4'd3, 1, 1, 4'd2, 1, 0, 0); #1;
    chk("prerst_ctl", ctl, 7'b1110100);
    rst_n = 1'b0; #1;
    chk("arst_ctl", ctl, 7'b0);
    chk("arst_sv", stage_valid, 3'b000);
    chk("arst_hlt", hlt, 1'b0);
    chk("arst_data1", id_data1, 16'h1111);
    #2 rst_n = 1'b1;
    idle(); tick();
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd0, 1, 0, 0); tick();
    set_id(1, 4'd0, 4'd0, 1, 1, 4'd0, 0, 0, 0); #1;
    chk("resume_sv", stage_valid, 3'b001);
    chk("zero_reg1", id_data1, 16'h1111);
    chk("zero_reg2", id_data2, 16'h2222);
    tick(); idle(); repeat (3) tick();

    // HLT flushed by a taken branch
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd1, 1, 0, 0); tick();
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0); tick();
    set_id(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 1);
    ex_branch_taken = 1'b1; #1;
    chk("brhlt_ctl", ctl, 7'b0010100);
    tick();
    ex_branch_taken = 1'b0; idle(); #1;
    chk("brhlt_nostop", ctl, 7'b0);
    repeat (4) tick();
    chk("brhlt_hlt", hlt, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard, forwarding and pipeline-sequencing controller for the 5-stage (IF/ID/EX/MEM/WB) pipelined CPU. It replaces fixed-stall, single-source forwarding with tracked per-stage records, which add:
- EX/MEM/WB-priority forwarding
- load-use bubble insertion
- taken-branch flush
- multi-cycle memory freeze
- HLT drain with a sticky halt output

It sits beside the pipeline registers and drives their stall/flush inputs and the ID operand muxes.

Parameters:
DATA_W, 16, operand/result width
REG_AW, 4, register address width
ZERO_REG_HARD, 1, 1: register 0 is never a forwarding match (reads as zero)
LOAD_USE_STALL, 1, 1: insert bubble on load-use; 0: no stall, WB/RF value used (compiler-scheduled code)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_AW  ID source register 1
id_src2  in  REG_AW  ID source register 2
id_use_src1  in  1  ID instruction reads src1
id_use_src2  in  1  ID instruction reads src2
id_dst  in  REG_AW  ID destination register
id_reg_write  in  1  ID instruction writes the register file
id_is_load  in  1  ID instruction is LW
id_is_hlt  in  1  ID instruction is HLT
ex_branch_taken  in  1  EX resolved a taken branch this cycle
mem_busy  in  1  data memory not ready (multi-cycle access)
id_rf_data1  in  DATA_W  register-file read 1
id_rf_data2  in  DATA_W  register-file read 2
ex_result  in  DATA_W  EX ALU result
mem_result  in  DATA_W  MEM write-back value (load data / LHB / LLB / PCS / ALU)
wb_result  in  DATA_W  WB write value
id_data1  out  DATA_W  forwarded operand 1
id_data2  out  DATA_W  forwarded operand 2
pc_stall  out  1  hold the PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  bubble IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  bubble ID/EX
ex_mem_stall  out  1  hold EX/MEM
mem_wb_flush  out  1  bubble MEM/WB
stage_valid  out  3  {wb,mem,ex} record valid bits
hlt  out  1  sticky halt

Behaviour:
Stage records
- Internal registers ex_r, mem_r, wb_r, each {valid, dst, reg_write, is_load, is_hlt}.
- Async reset clears all records, fetch_stop and hlt. All outputs then evaluate to 0 (given idle inputs).
- Normal clock: ex_r<=ID fields (valid = id_valid), mem_r<=ex_r, wb_r<=mem_r.

Forwarding (combinational, per operand)
- Priority: EX, then MEM, then WB, then RF.
- A stage matches when: record valid, reg_write=1, dst==src, and use_src=1.
- With ZERO_REG_HARD=1, src==0 never matches.
- An EX match with ex_r.is_load=1 is not forwarded from EX; lower stages are checked.

Load-use (LOAD_USE_STALL=1)
- Condition: EX load matches a used ID source.
- Response for 1 cycle: pc_stall=1, if_id_stall=1, id_ex_flush=1.
- Next edge: ex_r.valid<=0, mem_r<=ex_r; the load then forwards from MEM.

Taken branch (ex_branch_taken & ex_r.valid & ~mem_busy)
- if_id_flush=1 and id_ex_flush=1, with pc_stall=0 so the PC loads the target.
- Next edge: ex_r.valid<=0.
- Overrides load-use in the same cycle.

mem_busy
- Asserts pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush.
- ex_r and mem_r hold; wb_r.valid<=0.
- Highest priority: suppresses branch flush and load-use for that cycle; both are re-evaluated when busy drops.

HLT
- When id_is_hlt & id_valid and no stall/flush applies to ID that cycle: fetch_stop<=1.
- While fetch_stop=1: pc_stall=1, if_id_flush=1.
- A HLT flushed by a branch never sets fetch_stop.
- hlt<=1 on the edge after wb_r.valid & wb_r.is_hlt; it stays 1 until reset.
- Older instructions drain and write back normally.

Reset mid-operation
- Takes effect immediately (asynchronous); in-flight records are discarded.
- Operation resumes cleanly on the first edge after rst_n rises.

Decomposition:
- Shared package: stage-record field offsets/width, and opcode constants (LW=8, SW=9, LHB=A, LLB=B, B=C, BR=D, PCS=E, HLT=F).
- One natural sub-module, hazard_fwd_mux: per-operand priority match and select. Instantiate it twice.

Test Plan:
- ADD R1,R2,R3 followed by SUB R4,R1,R5; ex_result=0x0042 → id_data1=0x0042, no stall.
- LW R1 followed by ADD R2,R1,R3 → one cycle with pc_stall=1, if_id_stall=1, id_ex_flush=1; next cycle MEM match: id_data1=mem_result=0xBEEF, stage_valid[0]=0.
- ex_branch_taken=1 while a load-use condition also exists → if_id_flush=id_ex_flush=1, pc_stall=0; after the edge ex_r.valid=0.
- mem_busy high for 3 cycles with an ADD in EX → all stalls high and mem_wb_flush=1 for those 3 cycles; ex_r/mem_r unchanged; wb valid=0.
- HLT after ADD R1; the branch ahead of the HLT is not taken → pc frozen, ADD writes back, hlt rises 3 edges after HLT leaves ID and stays 1. Repeat with the branch taken → hlt stays 0.
- rst_n low mid-stream with a load-use condition active → all outputs 0 at once and stage_valid=0; src==0 with ex dst=0 → id_data=id_rf_data.
